wb_buffer: RTL and testbench

WB_BUFFER -- requirements
Module: wb_buffer

---
 rtl/legv8_pkg.sv | 9 +
 rtl/wb_fifo.sv | 72 +++++++
 rtl/wb_buffer.sv | 128 ++++++++++++
 tb/tb_wb_buffer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 constants for the write-back path: datapath width, register address width,
// and the zero-register index.
package legv8_pkg;

  localparam int unsigned WORD       = 64;
  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] XZR = 5'd31;

endpackage

// File: rtl/wb_fifo.sv
// Pending-write storage for wb_buffer. It holds a circular array of {reg, data} entries with
// read/write pointers and an occupancy count, and exposes the whole array for forwarding lookup.
module wb_fifo
  import legv8_pkg::REG_ADDR_W;
#(
  parameter int unsigned WORD  = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                push,
  input  logic                                pop,
  input  logic [REG_ADDR_W-1:0]               push_reg,
  input  logic [WORD-1:0]                     push_data,
  output logic [$clog2(DEPTH):0]              count,
  output logic                                full,
  output logic [$clog2(DEPTH)-1:0]            rd_ptr,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]    mem_reg,
  output logic [DEPTH-1:0][WORD-1:0]          mem_data
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [DEPTH-1:0][REG_ADDR_W-1:0] reg_q;
  logic [DEPTH-1:0][WORD-1:0]       data_q;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset; count_q alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push) begin
      reg_q[wr_ptr_q]  <= push_reg;
      data_q[wr_ptr_q] <= push_data;
    end
  end

  assign count    = count_q;
  assign full     = (count_q == CW'(DEPTH));
  assign rd_ptr   = rd_ptr_q;
  assign mem_reg  = reg_q;
  assign mem_data = data_q;

endmodule

// File: rtl/wb_buffer.sv
// Write-back buffer: queues register-file writes, issues them in order when the write port
// is free, and forwards the newest pending value to two read ports.
module wb_buffer
  import legv8_pkg::REG_ADDR_W;
  import legv8_pkg::XZR;
#(
  parameter int unsigned WORD  = legv8_pkg::WORD,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [REG_ADDR_W-1:0]    in_reg,
  input  logic [WORD-1:0]          in_data,
  input  logic                     drain_en,
  output logic                     RegWrite,
  output logic [REG_ADDR_W-1:0]    w_reg,
  output logic [WORD-1:0]          w_data,
  input  logic [REG_ADDR_W-1:0]    q_reg1,
  input  logic [REG_ADDR_W-1:0]    q_reg2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [WORD-1:0]          fwd_data1,
  output logic [WORD-1:0]          fwd_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [CW-1:0]                    count_w;
  logic                             full;
  logic [PW-1:0]                    rd_ptr;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] mem_reg;
  logic [DEPTH-1:0][WORD-1:0]       mem_data;

  logic accept, enq, pop;

  // in_ready depends only on state, never on in_valid.
  assign in_ready = !full;
  assign accept   = in_valid && in_ready;
  assign enq      = accept && (in_reg != XZR);
  assign pop      = drain_en && (count_w != '0);

  wb_fifo #(
    .WORD  (WORD),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (enq),
    .pop       (pop),
    .push_reg  (in_reg),
    .push_data (in_data),
    .count     (count_w),
    .full      (full),
    .rd_ptr    (rd_ptr),
    .mem_reg   (mem_reg),
    .mem_data  (mem_data)
  );

  logic                  regwrite_q, regwrite_d;
  logic [REG_ADDR_W-1:0] w_reg_q, w_reg_d;
  logic [WORD-1:0]       w_data_q, w_data_d;

  always_comb begin
    regwrite_d = pop;
    w_reg_d    = w_reg_q;
    w_data_d   = w_data_q;
    if (pop) begin
      w_reg_d  = mem_reg[rd_ptr];
      w_data_d = mem_data[rd_ptr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwrite_q <= 1'b0;
      w_reg_q    <= '0;
      w_data_q   <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      w_reg_q    <= w_reg_d;
      w_data_q   <= w_data_d;
    end
  end

  assign RegWrite = regwrite_q;
  assign w_reg    = w_reg_q;
  assign w_data   = w_data_q;
  assign count    = count_w;

  logic [1:0][REG_ADDR_W-1:0] q_regs;
  assign q_regs = {q_reg2, q_reg1};

  // Scan port entry first, then queue oldest to newest so the newest queued match wins.
  for (genvar p = 0; p < 2; p++) begin : g_fwd
    logic            hit;
    logic [WORD-1:0] data;
    logic [PW-1:0]   idx;

    always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      if (q_regs[p] != XZR) begin
        if (regwrite_q && (w_reg_q == q_regs[p])) begin
          hit  = 1'b1;
          data = w_data_q;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
          idx = rd_ptr + PW'(i);
          if ((CW'(i) < count_w) && (mem_reg[idx] == q_regs[p])) begin
            hit  = 1'b1;
            data = mem_data[idx];
          end
        end
      end
    end
  end

  assign fwd_hit1  = g_fwd[0].hit;
  assign fwd_data1 = g_fwd[0].data;
  assign fwd_hit2  = g_fwd[1].hit;
  assign fwd_data2 = g_fwd[1].data;

endmodule

// File: tb/tb_wb_buffer.sv
// Self-checking bench for wb_buffer: a cycle model with an expected-write queue, a forwarding
// vector table, directed corner sequences and a short random run.
module tb_wb_buffer;

  localparam int DEPTH = 4;
  localparam int WORD  = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_reg;
  logic [WORD-1:0]  in_data;
  logic             drain_en;
  logic             RegWrite;
  logic [4:0]       w_reg;
  logic [WORD-1:0]  w_data;
  logic [4:0]       q_reg1, q_reg2;
  logic             fwd_hit1, fwd_hit2;
  logic [WORD-1:0]  fwd_data1, fwd_data2;
  logic [2:0]       count;

  wb_buffer #(
    .WORD  (WORD),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_reg    (in_reg),
    .in_data   (in_data),
    .drain_en  (drain_en),
    .RegWrite  (RegWrite),
    .w_reg     (w_reg),
    .w_data    (w_data),
    .q_reg1    (q_reg1),
    .q_reg2    (q_reg2),
    .fwd_hit1  (fwd_hit1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data1 (fwd_data1),
    .fwd_data2 (fwd_data2),
    .count     (count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]      r;
    logic [WORD-1:0] d;
  } ent_t;

  typedef struct {
    int              ph;
    logic [4:0]      q1;
    logic [4:0]      q2;
    logic            h1;
    logic [WORD-1:0] d1;
    logic            h2;
    logic [WORD-1:0] d2;
  } fv_t;

  ent_t            sb[$];
  fv_t             fv[11];
  int              m_cnt;
  logic            m_rw;
  logic [4:0]      m_wreg;
  logic [WORD-1:0] m_wdata;
  int              checks;
  int              errors;

  task automatic chk(input string name, input logic [WORD-1:0] act, input logic [WORD-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; model advances and DUT outputs are compared #1 after the edge.
  task automatic step(input logic v, input logic [4:0] r, input logic [WORD-1:0] d,
                      input logic de);
    ent_t e;
    logic acc;
    in_valid = v;
    in_reg   = r;
    in_data  = d;
    drain_en = de;
    #1;
    chk("in_ready", in_ready, (m_cnt < DEPTH));
    acc  = v && (m_cnt < DEPTH);
    m_rw = 1'b0;
    if (de && m_cnt > 0) begin
      e       = sb.pop_front();
      m_rw    = 1'b1;
      m_wreg  = e.r;
      m_wdata = e.d;
      m_cnt--;
    end
    if (acc && r != 5'd31) begin
      sb.push_back('{r: r, d: d});
      m_cnt++;
    end
    @(posedge clk);
    #1;
    chk("RegWrite", RegWrite, m_rw);
    chk("w_reg", w_reg, m_wreg);
    chk("w_data", w_data, m_wdata);
    chk("count", count, m_cnt);
    in_valid = 1'b0;
  endtask

  task automatic check_fwd(input int ph);
    foreach (fv[i]) begin
      if (fv[i].ph == ph) begin
        q_reg1 = fv[i].q1;
        q_reg2 = fv[i].q2;
        #1;
        chk($sformatf("fwd_hit1[%0d]", i), fwd_hit1, fv[i].h1);
        chk($sformatf("fwd_data1[%0d]", i), fwd_data1, fv[i].d1);
        chk($sformatf("fwd_hit2[%0d]", i), fwd_hit2, fv[i].h2);
        chk($sformatf("fwd_data2[%0d]", i), fwd_data2, fv[i].d2);
      end
    end
    q_reg1 = '0;
    q_reg2 = '0;
  endtask

  task automatic model_fwd(input logic [4:0] q, output logic h, output logic [WORD-1:0] d);
    h = 1'b0;
    d = '0;
    if (q != 5'd31) begin
      if (m_rw && m_wreg == q) begin
        h = 1'b1;
        d = m_wdata;
      end
      foreach (sb[i]) begin
        if (sb[i].r == q) begin
          h = 1'b1;
          d = sb[i].d;
        end
      end
    end
  endtask

  function automatic logic [4:0] pick_reg();
    int k;
    k = $urandom_range(0, 4);
    return (k == 4) ? 5'd31 : 5'(k + 1);
  endfunction

  initial begin
    logic            eh1, eh2;
    logic [WORD-1:0] ed1, ed2;

    fv[0]  = '{ph: 0, q1: 31, q2: 11, h1: 0, d1: 0,  h2: 0, d2: 0};
    fv[1]  = '{ph: 1, q1: 5,  q2: 6,  h1: 1, d1: 9,  h2: 1, d2: 60};
    fv[2]  = '{ph: 1, q1: 5,  q2: 4,  h1: 1, d1: 9,  h2: 0, d2: 0};
    fv[3]  = '{ph: 1, q1: 7,  q2: 31, h1: 0, d1: 0,  h2: 0, d2: 0};
    fv[4]  = '{ph: 1, q1: 31, q2: 5,  h1: 0, d1: 0,  h2: 1, d2: 9};
    fv[5]  = '{ph: 1, q1: 0,  q2: 2,  h1: 0, d1: 0,  h2: 0, d2: 0};
    fv[6]  = '{ph: 2, q1: 5,  q2: 13, h1: 1, d1: 9,  h2: 1, d2: 130};
    fv[7]  = '{ph: 2, q1: 6,  q2: 7,  h1: 0, d1: 0,  h2: 0, d2: 0};
    fv[8]  = '{ph: 3, q1: 5,  q2: 13, h1: 0, d1: 0,  h2: 0, d2: 0};
    fv[9]  = '{ph: 3, q1: 31, q2: 6,  h1: 0, d1: 0,  h2: 0, d2: 0};
    fv[10] = '{ph: 4, q1: 22, q2: 31, h1: 0, d1: 0,  h2: 0, d2: 0};

    checks   = 0;
    errors   = 0;
    m_cnt    = 0;
    m_rw     = 1'b0;
    m_wreg   = '0;
    m_wdata  = '0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_reg   = '0;
    in_data  = '0;
    drain_en = 1'b0;
    q_reg1   = '0;
    q_reg2   = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst RegWrite", RegWrite, 0);
    chk("rst w_reg", w_reg, 0);
    chk("rst w_data", w_data, 0);
    chk("rst count", count, 0);
    chk("rst in_ready", in_ready, 1);
    rst = 1'b0;

    // Single write: issues one cycle after acceptance, then RegWrite drops.
    step(1, 5'd11, 64'd100, 1);
    step(0, 5'd0, 64'd0, 1);
    chk("single w_reg", w_reg, 11);
    step(0, 5'd0, 64'd0, 1);

    // Fill, fifth push ignored, then drain in order.
    for (int i = 1; i <= 4; i++) step(1, 5'(i), 64'(i * 10), 0);
    chk("full count", count, 4);
    step(1, 5'd9, 64'd99, 0);
    for (int i = 1; i <= 4; i++) begin
      step(0, 5'd0, 64'd0, 1);
      chk("order w_reg", w_reg, i);
    end
    step(0, 5'd0, 64'd0, 1);

    // XZR writes are consumed but never enqueued or issued.
    step(1, 5'd31, 64'hDEAD, 1);
    step(0, 5'd0, 64'd0, 1);
    check_fwd(0);

    // Forwarding priority and full-with-pop.
    step(1, 5'd6, 64'd50, 0);
    step(1, 5'd5, 64'd7, 0);
    step(1, 5'd6, 64'd60, 0);
    step(1, 5'd5, 64'd9, 0);
    step(1, 5'd12, 64'd120, 1);
    chk("full+pop count", count, 3);
    check_fwd(1);
    step(1, 5'd13, 64'd130, 0);
    for (int i = 0; i < 3; i++) step(0, 5'd0, 64'd0, 1);
    check_fwd(2);
    step(0, 5'd0, 64'd0, 1);
    step(0, 5'd0, 64'd0, 0);
    check_fwd(3);

    // Reset mid-drain with 3 pending entries and a write on the port.
    for (int i = 0; i < 4; i++) step(1, 5'(20 + i), 64'(200 + i), 0);
    step(0, 5'd0, 64'd0, 1);
    rst = 1'b1;
    #1;
    chk("midrst RegWrite", RegWrite, 0);
    chk("midrst count", count, 0);
    chk("midrst w_reg", w_reg, 0);
    chk("midrst w_data", w_data, 0);
    chk("midrst in_ready", in_ready, 1);
    sb.delete();
    m_cnt   = 0;
    m_rw    = 1'b0;
    m_wreg  = '0;
    m_wdata = '0;
    check_fwd(4);
    @(posedge clk);
    #4;
    rst = 1'b0;
    step(1, 5'd30, 64'd300, 1);
    step(0, 5'd0, 64'd0, 1);
    chk("post-rst w_reg", w_reg, 30);
    for (int i = 0; i < 4; i++) step(0, 5'd0, 64'd0, 1);

    // Random traffic with model-checked forwarding.
    for (int n = 0; n < 300; n++) begin
      q_reg1 = pick_reg();
      q_reg2 = pick_reg();
      #1;
      model_fwd(q_reg1, eh1, ed1);
      model_fwd(q_reg2, eh2, ed2);
      chk("rnd fwd_hit1", fwd_hit1, eh1);
      chk("rnd fwd_data1", fwd_data1, ed1);
      chk("rnd fwd_hit2", fwd_hit2, eh2);
      chk("rnd fwd_data2", fwd_data2, ed2);
      step(1'($urandom_range(0, 1)), pick_reg(), {$urandom, $urandom},
           ($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
